spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Host-side SPI master that sequences complete RAM accesses on the single-bit SPI slave/RAM interface. A host issues one read or write request with an 8-bit address; the controller generates the required address and data frames on SS_n/MOSI, captures returned read data from MISO, and reports completion. It sits between a host register/bus front end and `spi_Interface`, sharing its clock.

## Interface
- GAP_CYCLES, 3, cycles SS_n held high between frames and after the final frame; legal range 1..15.
- RD_LAT, 2, cycles between the last MOSI bit of a read-data frame and the first valid MISO bit; legal range 1..15.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  host request; accepted on a rising edge where req && ready.
- op  input  1  1 = read, 0 = write; captured at acceptance.
- addr  input  8  RAM address; captured at acceptance.
- wdata  input  8  write data; captured at acceptance.
- ready  output  1  controller idle and able to accept; reset 1.
- done  output  1  one-cycle completion pulse; reset 0.
- rdata  output  8  last read result, valid from done and held until the next read's done; reset 0x00.
- SS_n  output  1  slave select, active low; reset 1.
- MOSI  output  1  serial data to slave; reset 0.
- MISO  input  1  serial data from slave.

## Operation
- Frame: cycle 0 (CS_SETUP) SS_n=0, MOSI=0 (dummy, slave enters command check); cycles 1..10 (SHIFT_OUT) MOSI = din[9]..din[0], MSB first; din[9:8] = command, din[7:0] = payload. Slave reads din[9] as the read/write select.
- Commands: 00 write address, 01 write data, 10 read address, 11 read data (payload 0x00).
- Write op = frame 00+addr, then frame 01+wdata. Read op = frame 10+addr, then frame 11+0x00 followed by TURN (RD_LAT cycles, MOSI=0) and SHIFT_IN (8 cycles, MISO sampled MSB first).
- States: IDLE -> CS_SETUP -> SHIFT_OUT -> (TURN -> SHIFT_IN, read-data frame only) -> GAP -> CS_SETUP (next frame) or DONE -> IDLE.
- SS_n low in CS_SETUP, SHIFT_OUT, TURN, SHIFT_IN; high in all other states.
- DONE lasts exactly one cycle, done=1; rdata updated in the same cycle for reads; writes leave rdata unchanged.
- req while ready=0 is ignored (not queued); input changes after acceptance have no effect.
- rst asserted at any time: SS_n=1, MOSI=0, ready=1, done=0, rdata=0x00, state IDLE, address cache cleared; an interrupted operation never produces done.

## Timing
- Acceptance at edge E: ready=0 and SS_n=0 from E+1.
- Address/write-data frame: SS_n low 11 cycles. Read-data frame: 11+RD_LAT+8 cycles.
- Write, defaults: frame A cycles E+1..E+11, gap E+12..E+14, frame B E+15..E+25, gap E+26..E+28, done at E+29, ready=1 from E+30.
- Read, defaults: frame A E+1..E+11, gap E+12..E+14, frame B E+15..E+35 (MISO bits sampled E+28..E+35), gap E+36..E+38, done at E+39, ready=1 from E+40.
- Back-to-back: req held high is accepted again on the first edge ready=1; minimum GAP_CYCLES SS_n-high between operations is always guaranteed.

## Configuration
- SPI_CTRL_ADDR_CACHE_EN defined: controller keeps separate last-write-address and last-read-address registers with valid bits; if the accepted op's addr matches the valid cached address of the same type, the address frame and its gap are skipped (slave holds the address). Cache updated when an address frame completes; cleared by rst. Cached write latency: done at E+15; cached read: done at E+25.
- Not defined: every op sends both frames; no cache registers exist.

## Test plan
- Reset: rst=1 mid read frame B -> SS_n=1, ready=1, done=0, rdata=0x00 within the reset cycle; no done after release.
- Write addr=0x3C wdata=0xA5 -> MOSI frames 00_0011_1100 then 01_1010_0101, done at E+29, RAM[0x3C]=0xA5.
- Read addr=0x3C after above -> frames 10_0011_1100 and 11_0000_0000, rdata=0xA5 at done E+39.
- req pulsed while busy -> ignored; only one done, SS_n-high gap >=3 cycles between consecutive ops.
- With SPI_CTRL_ADDR_CACHE_EN: two writes to 0x10 (0x11, 0x22) -> second op sends only the 01 frame, done at E+15, RAM[0x10]=0x22; write to 0x11 sends both frames.
- With SPI_CTRL_ADDR_CACHE_EN: read 0x10 after a write to 0x10 -> read-address frame still sent (separate cache), rdata=0x22.

Source files
------------

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_ctrl
//  Purpose  : Host-side SPI master that sequences address/data frames for RAM
//             reads and writes on the single-bit SPI slave interface.
//  Options  : SPI_CTRL_ADDR_CACHE_EN - skip address frame on cached address hit
//  Revision : 1.0  initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int GAP_CYCLES = 3,
    parameter int RD_LAT     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       op,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CS_SETUP  = 3'd1,
        S_SHIFT_OUT = 3'd2,
        S_TURN      = 3'd3,
        S_SHIFT_IN  = 3'd4,
        S_GAP       = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [3:0] C_SHIFT_LAST = 4'd9;
    localparam logic [3:0] C_SHIN_LAST  = 4'd7;
    localparam logic [3:0] C_TURN_LAST  = 4'(RD_LAT - 1);
    localparam logic [3:0] C_GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  sh_q, sh_d;
    logic        data_frame_q, data_frame_d;
    logic        op_q, op_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  shin_q, shin_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        w_hit;

`ifdef SPI_CTRL_ADDR_CACHE_EN
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wa_q, wa_d;
    logic [7:0]  ra_q, ra_d;
    logic        wa_vld_q, wa_vld_d;
    logic        ra_vld_q, ra_vld_d;

    // Slave keeps separate write and read address registers, so each is cached alone
    assign w_hit = op ? (ra_vld_q && (ra_q == addr)) : (wa_vld_q && (wa_q == addr));
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        data_frame_d = data_frame_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        shin_d       = shin_q;
        rdata_d      = rdata_q;
`ifdef SPI_CTRL_ADDR_CACHE_EN
        addr_d       = addr_q;
        wa_d         = wa_q;
        ra_d         = ra_q;
        wa_vld_d     = wa_vld_q;
        ra_vld_d     = ra_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = op;
                    wdata_d = wdata;
                    cnt_d   = 4'd0;
                    state_d = S_CS_SETUP;
`ifdef SPI_CTRL_ADDR_CACHE_EN
                    addr_d  = addr;
`endif
                    if (w_hit) begin
                        data_frame_d = 1'b1;
                        sh_d         = {op, 1'b1, (op ? 8'h00 : wdata)};
                    end else begin
                        data_frame_d = 1'b0;
                        sh_d         = {op, 1'b0, addr};
                    end
                end
            end
            S_CS_SETUP: begin
                cnt_d   = 4'd0;
                state_d = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                sh_d  = {sh_q[8:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == C_SHIFT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = (data_frame_q && op_q) ? S_TURN : S_GAP;
`ifdef SPI_CTRL_ADDR_CACHE_EN
                    if (!data_frame_q) begin
                        if (op_q) begin
                            ra_d     = addr_q;
                            ra_vld_d = 1'b1;
                        end else begin
                            wa_d     = addr_q;
                            wa_vld_d = 1'b1;
                        end
                    end
`endif
                end
            end
            S_TURN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == C_TURN_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT_IN;
                end
            end
            S_SHIFT_IN: begin
                shin_d = {shin_q[6:0], MISO};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == C_SHIN_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == C_GAP_LAST) begin
                    cnt_d = 4'd0;
                    if (data_frame_q) begin
                        state_d = S_DONE;
                        if (op_q) begin
                            rdata_d = shin_q;
                        end
                    end else begin
                        state_d      = S_CS_SETUP;
                        data_frame_d = 1'b1;
                        sh_d         = {op_q, 1'b1, (op_q ? 8'h00 : wdata_q)};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            sh_q         <= 10'd0;
            data_frame_q <= 1'b0;
            op_q         <= 1'b0;
            wdata_q      <= 8'h00;
            shin_q       <= 8'h00;
            rdata_q      <= 8'h00;
`ifdef SPI_CTRL_ADDR_CACHE_EN
            addr_q       <= 8'h00;
            wa_q         <= 8'h00;
            ra_q         <= 8'h00;
            wa_vld_q     <= 1'b0;
            ra_vld_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            data_frame_q <= data_frame_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            shin_q       <= shin_d;
            rdata_q      <= rdata_d;
`ifdef SPI_CTRL_ADDR_CACHE_EN
            addr_q       <= addr_d;
            wa_q         <= wa_d;
            ra_q         <= ra_d;
            wa_vld_q     <= wa_vld_d;
            ra_vld_q     <= ra_vld_d;
`endif
        end
    end

    // Outputs decode directly from state so reset forces them without waiting for a clock
    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign rdata = rdata_q;
    assign SS_n  = !((state_q == S_CS_SETUP) || (state_q == S_SHIFT_OUT) ||
                     (state_q == S_TURN)     || (state_q == S_SHIFT_IN));
    assign MOSI  = (state_q == S_SHIFT_OUT) && sh_q[9];

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_ctrl
//  Purpose  : Self-checking bench for spi_master_ctrl with a behavioural SPI
//             RAM slave; honours SPI_CTRL_ADDR_CACHE_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_master_ctrl;

    localparam int GAP = 3;
    localparam int LAT = 2;
`ifdef SPI_CTRL_ADDR_CACHE_EN
    localparam bit CACHED = 1'b1;
`else
    localparam bit CACHED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       op = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       ready, done, SS_n, MOSI;
    logic [7:0] rdata;
    logic       MISO = 1'b0;

    spi_master_ctrl #(.GAP_CYCLES(GAP), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Behavioural SPI RAM slave: decodes frames, drives MISO for read-data frames
    logic [7:0] ram [256] = '{default: 8'h00};
    logic [9:0] frames [$];
    int         gaps [$];
    logic [9:0] s_din = 10'd0;
    logic [7:0] s_waddr = 8'h00, s_raddr = 8'h00, s_rbyte = 8'h00;
    logic       s_rd = 1'b0, s_seen_low = 1'b0;
    int         s_pos = 0, s_hi = 0;

    always @(negedge clk) begin
        if (SS_n) begin
            s_pos = 0;
            s_rd  = 1'b0;
            MISO  = 1'b0;
            s_hi  = s_hi + 1;
        end else begin
            if (s_seen_low && s_hi > 0) gaps.push_back(s_hi);
            s_hi = 0;
            s_seen_low = 1'b1;
            if (s_pos >= 1 && s_pos <= 10) s_din[10 - s_pos] = MOSI;
            if (s_pos == 10) begin
                frames.push_back(s_din);
                case (s_din[9:8])
                    2'b00: s_waddr = s_din[7:0];
                    2'b01: ram[s_waddr] = s_din[7:0];
                    2'b10: s_raddr = s_din[7:0];
                    default: begin
                        s_rbyte = ram[s_raddr];
                        s_rd    = 1'b1;
                    end
                endcase
            end
            if (s_rd && s_pos >= 11 + LAT && s_pos <= 18 + LAT)
                MISO = s_rbyte[7 - (s_pos - 11 - LAT)];
            else
                MISO = 1'b0;
            s_pos = s_pos + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] d;
        logic [9:0] fa;
        logic [9:0] fb;
        logic [7:0] rd;
        logic       hit;
    } vec_t;

    vec_t vt [12];

    initial begin
        vec_t v;
        bit   skip;
        int   base, nf, lat, exp_lat, dcnt, t1, t2, mg, fidx;

        vt[0]  = '{1'b0, 8'h3C, 8'hA5, 10'h03C, 10'h1A5, 8'h00, 1'b0};
        vt[1]  = '{1'b1, 8'h3C, 8'h00, 10'h23C, 10'h300, 8'hA5, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 8'hFF, 10'h000, 10'h1FF, 8'hA5, 1'b0};
        vt[3]  = '{1'b0, 8'hFF, 8'h00, 10'h0FF, 10'h100, 8'hA5, 1'b0};
        vt[4]  = '{1'b1, 8'hFF, 8'h00, 10'h2FF, 10'h300, 8'h00, 1'b0};
        vt[5]  = '{1'b1, 8'h00, 8'h00, 10'h200, 10'h300, 8'hFF, 1'b0};
        vt[6]  = '{1'b0, 8'h10, 8'h11, 10'h010, 10'h111, 8'hFF, 1'b0};
        vt[7]  = '{1'b0, 8'h10, 8'h22, 10'h010, 10'h122, 8'hFF, 1'b1};
        vt[8]  = '{1'b0, 8'h11, 8'h5A, 10'h011, 10'h15A, 8'hFF, 1'b0};
        vt[9]  = '{1'b1, 8'h10, 8'h00, 10'h210, 10'h300, 8'h22, 1'b0};
        vt[10] = '{1'b1, 8'h10, 8'h00, 10'h210, 10'h300, 8'h22, 1'b1};
        vt[11] = '{1'b0, 8'h11, 8'h77, 10'h011, 10'h177, 8'h22, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_ssn", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_rdata", rdata, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            v = vt[i];
            skip = CACHED && v.hit;
            exp_lat = skip ? (v.op ? 25 : 15) : (v.op ? 39 : 29);
            @(negedge clk);
            chk("ready_idle", ready, 1);
            base = frames.size();
            req = 1'b1; op = v.op; addr = v.a; wdata = v.d;
            @(posedge clk);
            @(negedge clk);
            req = 1'b0; op = ~v.op; addr = ~v.a; wdata = ~v.d;
            chk("ready_busy", ready, 0);
            chk("ssn_low_e1", SS_n, 0);
            lat = -1;
            for (int n = 1; n <= 100; n++) begin
                if (done) begin
                    lat = n;
                    break;
                end
                @(negedge clk);
            end
            chk("latency", lat, exp_lat);
            chk("rdata", rdata, v.rd);
            nf = frames.size() - base;
            chk("nframes", nf, skip ? 1 : 2);
            if (!skip && nf >= 1) chk("frame_a", frames[base], v.fa);
            fidx = skip ? 0 : 1;
            if (nf > fidx) chk("frame_b", frames[base + fidx], v.fb);
            if (!v.op) chk("ram_write", ram[v.a], v.d);
            @(negedge clk);
            chk("ready_after", ready, 1);
            chk("done_one_cycle", done, 0);
        end

        // Reset in the middle of a read-data frame
        @(negedge clk);
        req = 1'b1; op = 1'b1; addr = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (22) @(negedge clk);
        chk("mid_read_ssn", SS_n, 0);
        rst = 1'b1;
        #1;
        chk("arst_ssn", SS_n, 1);
        chk("arst_ready", ready, 1);
        chk("arst_done", done, 0);
        chk("arst_rdata", rdata, 8'h00);
        chk("arst_mosi", MOSI, 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_done_after_rst", dcnt, 0);

        // Request pulsed while busy must be dropped
        base = frames.size();
        req = 1'b1; op = 1'b0; addr = 8'h11; wdata = 8'h33;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        req = 1'b1; op = 1'b1; addr = 8'h3C;
        @(negedge clk);
        req = 1'b0;
        dcnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("busy_one_done", dcnt, 1);
        chk("busy_nframes", frames.size() - base, 2);
        chk("busy_ram", ram[8'h11], 8'h33);
        chk("busy_rdata", rdata, 8'h00);

        // req held high: re-accepted on first ready edge
        base = gaps.size();
        nf = frames.size();
        t1 = -1; t2 = -1;
        req = 1'b1; op = 1'b0; addr = 8'h40; wdata = 8'h44;
        for (int n = 0; n < 150 && t2 < 0; n++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) t1 = n;
                else t2 = n;
            end
            if (t1 >= 0 && n == t1 + 2) req = 1'b0;
        end
        req = 1'b0;
        chk("b2b_interval", t2 - t1, CACHED ? 16 : 30);
        chk("b2b_nframes", frames.size() - nf, CACHED ? 3 : 4);
        mg = 99;
        for (int k = base; k < gaps.size(); k++) if (gaps[k] < mg) mg = gaps[k];
        chk("b2b_min_gap", mg, GAP);
        chk("b2b_ram", ram[8'h40], 8'h44);
        repeat (40) @(negedge clk);
        chk("b2b_idle_ready", ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
